// File: rtl/bpd_update_scheduler_if.sv
// Handshake bundle between the commit/repair producers, the predictor update
// port and the update scheduler.
interface bpd_update_scheduler_if #(
  parameter int DATA_W = 256,
  parameter int QDEPTH = 4
);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic              io_flush;
  logic              io_commit_valid;
  logic              io_commit_ready;
  logic [DATA_W-1:0] io_commit_bits;
  logic              io_repair_valid;
  logic              io_repair_ready;
  logic [DATA_W-1:0] io_repair_bits;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [DATA_W-1:0] io_out_bits;
  logic              io_out_chosen;
  logic [CNT_W-1:0]  io_count;

  modport master (
    output io_flush, io_commit_valid, io_commit_bits,
           io_repair_valid, io_repair_bits, io_out_ready,
    input  io_commit_ready, io_repair_ready, io_out_valid,
           io_out_bits, io_out_chosen, io_count
  );

  modport slave (
    input  io_flush, io_commit_valid, io_commit_bits,
           io_repair_valid, io_repair_bits, io_out_ready,
    output io_commit_ready, io_repair_ready, io_out_valid,
           io_out_bits, io_out_chosen, io_count
  );
endinterface

// File: rtl/bpd_update_scheduler.sv
// Branch-predictor update sequencer: buffered commit stream plus unbuffered
// high-priority repair stream, arbitrated into one registered output.
module bpd_update_scheduler #(
  parameter int DATA_W     = 256,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 7
) (
  input logic                   clock,
  input logic                   reset,
  bpd_update_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  logic [DATA_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve_cnt;

  logic              vld_p1;
  logic [DATA_W-1:0] bits_p1;
  logic              chosen_p1;

  logic kill;
  logic load;
  logic nonempty;
  logic force_commit;
  logic repair_ready;
  logic commit_ready;
  logic enq;
  logic repair_win;
  logic deq;

  // Reset is treated like a flush so neither producer sees a completed handshake.
  always_comb begin
    kill         = reset | bus.io_flush;
    load         = ~vld_p1 | bus.io_out_ready;
    nonempty     = (count != '0);
    force_commit = (starve_cnt == SC_W'(STARVE_MAX)) & nonempty;
    repair_ready = load & ~force_commit & ~kill;
    commit_ready = (count != CNT_W'(QDEPTH)) & ~kill;
    enq          = bus.io_commit_valid & commit_ready;
    repair_win   = bus.io_repair_valid & repair_ready;
    deq          = load & ~kill & ~repair_win & nonempty;
  end

  always_ff @(posedge clock) begin
    if (enq) mem[tail] <= bus.io_commit_bits;
  end

  always_ff @(posedge clock) begin
    if (kill) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      vld_p1     <= 1'b0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      if (deq || !nonempty)
        starve_cnt <= '0;
      else if (repair_win && starve_cnt != SC_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + SC_W'(1);
      if (load) vld_p1 <= repair_win | deq;
    end
  end

  // Stage p1: output register, frozen while the predictor stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      bits_p1   <= '0;
      chosen_p1 <= 1'b0;
    end else if (!bus.io_flush && load) begin
      if (repair_win) begin
        bits_p1   <= bus.io_repair_bits;
        chosen_p1 <= 1'b0;
      end else if (deq) begin
        bits_p1   <= mem[head];
        chosen_p1 <= 1'b1;
      end
    end
  end

  assign bus.io_commit_ready = commit_ready;
  assign bus.io_repair_ready = repair_ready;
  assign bus.io_out_valid    = vld_p1;
  assign bus.io_out_bits     = bits_p1;
  assign bus.io_out_chosen   = chosen_p1;
  assign bus.io_count        = count;
endmodule

// File: doc/bpd_update_scheduler.md
# bpd_update_scheduler

Sequencing front end for the branch-predictor update port. Two producers feed it: the FTQ commit-update stream, buffered in a small FIFO, and the repair/mispredict stream, which is unbuffered and high priority. The block selects one update per cycle into a registered output stage that drives the predictor update bundle. An anti-starvation counter bounds how long commit updates can wait behind repairs, and a flush input discards all buffered state.

## Interface
- DATA_W, 256: opaque update payload width (pc, masks, cfi, ghist, target, meta packed by the producer).
- QDEPTH, 4: commit FIFO entries; power of two, ≥2.
- STARVE_MAX, 7: repair wins allowed over a waiting commit entry before the commit entry is forced.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- io_flush  in  1  discard FIFO contents and output register; synchronous.
- io_commit_valid  in  1  commit update offered.
- io_commit_ready  out  1  commit FIFO can accept.
- io_commit_bits  in  DATA_W  commit payload.
- io_repair_valid  in  1  repair/mispredict update offered.
- io_repair_ready  out  1  repair accepted this cycle.
- io_repair_bits  in  DATA_W  repair payload.
- io_out_valid  out  1  registered output holds an update.
- io_out_ready  in  1  predictor consumes the output.
- io_out_bits  out  DATA_W  registered payload.
- io_out_chosen  out  1  source of the registered payload: 0 = repair, 1 = commit.
- io_count  out  log2(QDEPTH)+1  current FIFO occupancy.

## Operation
- Commit FIFO:
  - Circular buffer with head and tail pointers plus occupancy count.
  - io_commit_ready = (count != QDEPTH) & ~io_flush.
  - Enqueue on io_commit_valid & io_commit_ready.
  - There is no bypass: an entry enqueued in cycle N is visible to selection no earlier than cycle N+1.
- Output register:
  - load = ~io_out_valid | io_out_ready.
  - When load is high and a candidate exists, the register captures the winner's bits and chosen, and io_out_valid is set.
  - When load is high and no candidate exists, io_out_valid is cleared.
- Selection, evaluated only when load is high and io_flush is low:
  - force = (starve_cnt == STARVE_MAX) & (count != 0).
  - If io_repair_valid & ~force: repair wins. io_repair_ready = 1 and chosen = 0.
  - Otherwise, if count != 0: the FIFO head wins. It is dequeued and chosen = 1.
  - io_repair_ready = load & ~force & ~io_flush.
- Starvation counter:
  - Width log2(STARVE_MAX+1).
  - Increments, saturating, when repair wins while count != 0.
  - Clears when a FIFO entry is dequeued or when count == 0.
  - Holds value otherwise.
- Simultaneous enqueue and dequeue leaves count unchanged. When full, a simultaneous dequeue does not make io_commit_ready high in the same cycle; readiness depends only on the registered count.
- io_flush:
  - Next cycle: count = 0, pointers = 0, io_out_valid = 0, starve_cnt = 0.
  - Both ready outputs are 0 during the flush cycle, and no handshake completes.
  - Flush dominates load; an out handshake coinciding with flush still counts as consumed.
- reset: identical to flush, and additionally io_out_bits = 0 and io_out_chosen = 0.

## Timing
- Reset values:
  - io_out_valid = 0, io_out_bits = 0, io_out_chosen = 0.
  - io_count = 0, so io_commit_ready = 1 the cycle after reset deasserts.
  - io_repair_ready = 1 the cycle after reset deasserts, because load = 1.
- Repair latency: accepted in cycle N, io_out_valid in cycle N+1.
- Commit latency: enqueued in N, earliest dequeue in N+1, io_out_valid in N+2.
- Throughput: one update per cycle with io_out_ready held high.
- Backpressure:
  - While io_out_valid & ~io_out_ready, io_out_bits and io_out_chosen are stable.
  - io_repair_ready = 0 and there is no dequeue during that stall.
- Pointer wrap: head and tail wrap modulo QDEPTH. Full vs. empty is distinguished by count only.
- io_repair_ready combinationally depends on io_out_ready and io_flush, not on io_repair_valid. io_commit_ready is a function of registered state and io_flush.

## Test plan
- Reset, then idle:
  - The cycle after reset: io_out_valid = 0, io_count = 0, both readies = 1.
  - One commit beat with bits 0xA5, io_out_ready = 1: io_out_valid = 1 two cycles later with bits 0xA5 and chosen = 1.
- Fill and stall:
  - io_out_ready = 0; push 5 commit beats.
  - The first beat moves to the output register. 4 fill the FIFO: io_count = 4, io_commit_ready = 0.
  - Then release io_out_ready: beats drain in order, one per cycle, and pointers wrap correctly on a second fill.
- Priority:
  - FIFO holds 1 entry; repair valid continuously with io_out_ready = 1.
  - Repairs win 7 consecutive cycles (chosen = 0); cycle 8 outputs the commit entry (chosen = 1) with io_repair_ready = 0.
  - Counter then clears.
- Repair backpressure: io_out_valid = 1 and io_out_ready = 0 with repair valid → io_repair_ready = 0; io_out_bits stays unchanged for 3 stalled cycles.
- Flush: FIFO holds 3 entries and the output is valid; assert io_flush one cycle → next cycle io_count = 0, io_out_valid = 0, and no entry from before the flush ever appears at the output.
- Reset mid-operation: assert reset while the FIFO is full and a repair is offered → next cycle all outputs at reset values, and the repair is not accepted.
